lcd_avalon_responder: RTL and testbench
=======================================

# lcd_avalon_responder

Avalon-MM slave that executes single-byte writes from the LCD master FSMs on an HD44780-compatible character LCD. It also exposes a readable busy/status byte. It latches each write, then generates the LCD RS/E/DATA timing sequence and holds off the next write with `waitrequest` until the LCD's execution time has elapsed. It sits between the text/menu master and the board LCD pins, in place of a vendor LCD controller.

## Interface
Parameters:
- `SETUP_CYCLES`, default 2: cycles with RS/DATA stable before E rises (≥40 ns at 50 MHz).
- `E_PULSE_CYCLES`, default 12: E high width.
- `HOLD_CYCLES`, default 1: cycles with E low and RS/DATA held after E falls.
- `CMD_WAIT_CYCLES`, default 2000: post-pulse execution wait for ordinary instructions and data.
- `CLEAR_WAIT_CYCLES`, default 82000: post-pulse wait for clear display and return home.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 1: 0 = instruction register (RS=0), 1 = data register (RS=1).
- `chipselect` in 1: slave select.
- `byteenable` in 1: byte lane enable.
- `read` in 1: read strobe.
- `write` in 1: write strobe.
- `writedata` in 8: byte to send.
- `waitrequest` out 1: high = write not accepted this cycle.
- `readdata` out 8: status/readback.
- `response` out 2: 00 OKAY, 10 SLAVEERROR.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: tied 0; write-only.
- `lcd_en` out 1: LCD enable strobe.
- `lcd_data` out 8: LCD data bus.
- `lcd_on` out 1: tied 1.
- `lcd_blon` out 1: tied 1.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
  - IDLE → SETUP on an accepted write.
  - Each other state advances when its down-counter reaches 0.
  - WAIT → IDLE.
- Accepted write: `chipselect & write & byteenable` in IDLE. On that edge the block latches `address` into `lcd_rs` and `writedata` into `lcd_data`.
- `lcd_en` is high only in PULSE. `lcd_rs` and `lcd_data` are stable from SETUP through HOLD and keep their value in WAIT and IDLE.
- Long wait: a write with address 0 and data 0x01, 0x02 or 0x03 uses CLEAR_WAIT_CYCLES. All other writes use CMD_WAIT_CYCLES.
- Counter width is `$clog2` of the largest parameter plus 1. A parameter value of 0 is illegal; the minimum is 1 cycle per phase.
- `waitrequest` is combinational: `chipselect & write & (state != IDLE)`. It is never asserted for reads.
- Write with `byteenable = 0` while in IDLE:
  - accepted with no LCD activity;
  - `response` = 10 in that cycle.
- Read (`chipselect & read & ~write`) completes in the same cycle and never waits:
  - address 0: `readdata` = {busy, 7'b0}, where busy = (state != IDLE);
  - address 1: `readdata` = last latched data byte.
- `readdata` is 0 when no read is active.
- Read and write asserted together: treated as a write only; `readdata` = 0.
- Reset values: state IDLE, `lcd_en` 0, `lcd_rs` 0, `lcd_data` 0x00, `readdata` 0, `response` 00. `waitrequest` is 0 unless the init sequence is compiled in (see Configuration).
- Reset during a transfer: `lcd_en` drops immediately (asynchronous). The pending write is discarded.

## Timing
- If a write is accepted in cycle T:
  - `lcd_en` is high for cycles T+1+S … T+S+P;
  - HOLD lasts H cycles;
  - WAIT lasts W cycles;
  - IDLE is re-entered at cycle T+1+S+P+H+W. That is the earliest cycle a held write can be accepted (`waitrequest` low).
  - S, P, H and W are the SETUP, PULSE, HOLD and selected WAIT cycle counts.
- A master holding `write` high through busy states is accepted exactly once, in the first IDLE cycle.
- Back-to-back writes carry no extra dead cycle beyond the above.

## Configuration
- `LCD_INIT_SEQ_EN` defined:
  - after reset deasserts, the block autonomously issues the instructions 0x38, 0x0C, 0x01, 0x06;
  - each uses full SETUP/PULSE/HOLD/WAIT timing, and 0x01 uses CLEAR_WAIT;
  - `waitrequest` is held at 1 for any write from reset until the sequence completes;
  - the busy status bit reads 1 during the sequence.
- `LCD_INIT_SEQ_EN` undefined: the block is IDLE immediately after reset, and no LCD activity occurs until the first host write.

## Test plan
Parameters for all scenarios: SETUP=2, PULSE=3, HOLD=1, CMD_WAIT=4, CLEAR_WAIT=10.
- **Single data write.** Write addr 1, data 0x6F at T → `lcd_rs`=1, `lcd_data`=0x6F from T+1; `lcd_en` high T+3..T+5; busy until T+11.
- **Clear timing.** Write addr 0, data 0x01 at T → `lcd_en` high T+3..T+5; `waitrequest` stays high for a held write until T+17; that write is accepted at T+17.
- **Held master stream.** Nine writes: 0x01, 'o','p','t','i','o','n',' ','1', each held until `waitrequest` drops → exactly nine E pulses, in that order, with correct RS on each.
- **Status read while busy.** Read addr 0 at T+4 → `readdata`=0x80, `waitrequest`=0. Read at T+11 → 0x00. Read addr 1 → 0x6F.
- **Error and reset.** Write with `byteenable`=0 → `response`=10 and no `lcd_en` pulse. Reset asserted at T+4 during a pulse → `lcd_en`=0 in the same cycle, state IDLE.
- **Init sequence.** With `LCD_INIT_SEQ_EN` defined, release reset → four E pulses carrying 0x38, 0x0C, 0x01, 0x06; a host write issued meanwhile is stalled and executes fifth.

Source files
------------

// File: rtl/lcd_avalon_responder.sv
// Avalon-MM slave that drives an HD44780 character LCD: latches single-byte writes and
// sequences RS/E/DATA timing. Define LCD_INIT_SEQ_EN to issue the power-on init sequence.
module lcd_avalon_responder #(
    parameter int SETUP_CYCLES      = 2,
    parameter int E_PULSE_CYCLES    = 12,
    parameter int HOLD_CYCLES       = 1,
    parameter int CMD_WAIT_CYCLES   = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       address,
    input  logic       chipselect,
    input  logic       byteenable,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic       waitrequest,
    output logic [7:0] readdata,
    output logic [1:0] response,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data,
    output logic       lcd_on,
    output logic       lcd_blon
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYCLES = max_of(max_of(max_of(SETUP_CYCLES, E_PULSE_CYCLES),
                                              max_of(HOLD_CYCLES, CMD_WAIT_CYCLES)),
                                       CLEAR_WAIT_CYCLES);
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    // Counters are loaded with N-1 so a phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(E_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             rs_reg;
    logic [7:0]       data_reg;
    logic             long_wait_reg;

    logic       init_pending;
    logic       start_init;
    logic [7:0] init_byte;
    logic       host_ok;
    logic       accept;
    logic       start;
    logic       start_rs;
    logic [7:0] start_data;
    logic       busy;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0] init_idx_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_idx_reg <= 3'd0;
        end else if (start_init) begin
            init_idx_reg <= init_idx_reg + 3'd1;
        end
    end

    // Pending until the last instruction has been launched; the FSM covers the rest.
    assign init_pending = (init_idx_reg != 3'd4);
    assign start_init   = (state_reg == IDLE) && init_pending;

    always_comb begin
        init_byte = 8'h00;
        case (init_idx_reg)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            3'd3:    init_byte = 8'h06;
            default: init_byte = 8'h00;
        endcase
    end
`else
    assign init_pending = 1'b0;
    assign start_init   = 1'b0;
    assign init_byte    = 8'h00;
`endif

    assign host_ok    = chipselect && write && (state_reg == IDLE) && !init_pending;
    assign accept     = host_ok && byteenable;
    assign start      = start_init || accept;
    assign start_rs   = start_init ? 1'b0 : address;
    assign start_data = start_init ? init_byte : writedata;
    assign busy       = (state_reg != IDLE) || init_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETUP;
                    count_next = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (count_reg == '0) begin
                    state_next = PULSE;
                    count_next = PULSE_LOAD;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            PULSE: begin
                if (count_reg == '0) begin
                    state_next = HOLD;
                    count_next = HOLD_LOAD;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            HOLD: begin
                if (count_reg == '0) begin
                    state_next = WAIT;
                    count_next = long_wait_reg ? CLEAR_LOAD : CMD_LOAD;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            WAIT: begin
                if (count_reg == '0) begin
                    state_next = IDLE;
                    count_next = '0;
                end else begin
                    count_next = count_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs_reg        <= 1'b0;
            data_reg      <= 8'h00;
            long_wait_reg <= 1'b0;
        end else if (start) begin
            rs_reg        <= start_rs;
            data_reg      <= start_data;
            long_wait_reg <= !start_rs && (start_data >= 8'h01) && (start_data <= 8'h03);
        end
    end

    always_comb begin
        lcd_en      = (state_reg == PULSE);
        waitrequest = chipselect && write && busy;
        response    = (host_ok && !byteenable) ? 2'b10 : 2'b00;
        readdata    = 8'h00;
        if (chipselect && read && !write) begin
            readdata = address ? data_reg : {busy, 7'b0};
        end
    end

    assign lcd_rs   = rs_reg;
    assign lcd_data = data_reg;
    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

endmodule

// File: tb/tb_lcd_avalon_responder.sv
// Randomized and directed bench for lcd_avalon_responder against a cycle-count
// reference model (accept cycle -> E window and busy-until cycle).
module tb_lcd_avalon_responder;
    localparam int S   = 2;
    localparam int P   = 3;
    localparam int H   = 1;
    localparam int CW  = 4;
    localparam int CLW = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       address = 1'b0;
    logic       chipselect = 1'b0;
    logic       byteenable = 1'b0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] writedata = 8'h00;
    logic       waitrequest;
    logic [7:0] readdata;
    logic [1:0] response;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;
    logic       lcd_on;
    logic       lcd_blon;

    lcd_avalon_responder #(
        .SETUP_CYCLES(S), .E_PULSE_CYCLES(P), .HOLD_CYCLES(H),
        .CMD_WAIT_CYCLES(CW), .CLEAR_WAIT_CYCLES(CLW)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .byteenable(byteenable), .read(read), .write(write), .writedata(writedata),
        .waitrequest(waitrequest), .readdata(readdata), .response(response),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data),
        .lcd_on(lcd_on), .lcd_blon(lcd_blon)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         idle_at = 0;
    int         en_start = -10;
    int         en_end = -10;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [8:0] exp_pulses[$];
    logic [8:0] obs_pulses[$];
    logic [7:0] init_q[$];
    logic       prev_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp_v);
    endtask

    task automatic model_reset();
        idle_at  = cyc;
        en_start = -10;
        en_end   = -10;
        m_rs     = 1'b0;
        m_data   = 8'h00;
        init_q.delete();
`ifdef LCD_INIT_SEQ_EN
        init_q.push_back(8'h38);
        init_q.push_back(8'h0C);
        init_q.push_back(8'h01);
        init_q.push_back(8'h06);
`endif
    endtask

    task automatic start_xfer(input logic a, input logic [7:0] d, input string who);
        int w;
        w        = (!a && d >= 8'h01 && d <= 8'h03) ? CLW : CW;
        en_start = cyc + 1 + S;
        en_end   = cyc + S + P;
        idle_at  = cyc + 1 + S + P + H + w;
        m_rs     = a;
        m_data   = d;
        exp_pulses.push_back({a, d});
        $display("cyc=%0d %s write rs=%0d data=%02h wait=%0d", cyc, who, a, d, w);
    endtask

    task automatic check_outputs();
        bit busy;
        bit rd;
        busy = (cyc < idle_at) || (init_q.size() != 0);
        rd   = chipselect && read && !write;
        check("waitrequest", 32'(waitrequest), 32'(chipselect && write && busy));
        check("lcd_en", 32'(lcd_en), 32'(cyc >= en_start && cyc <= en_end));
        check("lcd_rs", 32'(lcd_rs), 32'(m_rs));
        check("lcd_data", 32'(lcd_data), 32'(m_data));
        check("readdata", 32'(readdata), !rd ? 32'd0 : (address ? 32'(m_data) : (busy ? 32'h80 : 32'h00)));
        check("response", 32'(response), (chipselect && write && !byteenable && !busy) ? 32'd2 : 32'd0);
        check("tied_pins", 32'({lcd_rw, lcd_on, lcd_blon}), 32'h3);
    endtask

    // One clock: compare at negedge, advance the model at posedge, return 1 ns later.
    task automatic step(output bit accepted);
        @(negedge clk);
        if (!reset) check_outputs();
        if (lcd_en && !prev_en) obs_pulses.push_back({lcd_rs, lcd_data});
        prev_en = lcd_en;
        @(posedge clk);
        accepted = 1'b0;
        if (reset) begin
            model_reset();
        end else if (cyc >= idle_at && init_q.size() != 0) begin
            start_xfer(1'b0, init_q.pop_front(), "init");
        end else if (cyc >= idle_at && chipselect && write) begin
            accepted = 1'b1;
            if (byteenable) start_xfer(address, writedata, "host");
            else $display("cyc=%0d host write byteenable=0 slverr data=%02h", cyc, writedata);
        end else if (chipselect && read && !write) begin
            $display("cyc=%0d host read addr=%0d readdata=%02h", cyc, address, readdata);
        end
        cyc++;
        #1;
    endtask

    task automatic idle_steps(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic write_held(input logic a, input logic [7:0] d, output int at);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        at = -1;
        chipselect = 1'b1; write = 1'b1; read = 1'b0; byteenable = 1'b1;
        address = a; writedata = d;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 300);
        check("write_accepted", 32'(acc), 32'd1);
        if (acc) at = cyc - 1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic wait_idle();
        bit a;
        int n;
        n = 0;
        while ((cyc < idle_at || init_q.size() != 0) && n < 300) begin
            step(a);
            n++;
        end
        check("idle_reached", 32'(cyc >= idle_at && init_q.size() == 0), 32'd1);
    endtask

    task automatic read_now(input logic a, input logic [7:0] expv, input string tag);
        bit acc;
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        #1;
        check(tag, 32'(readdata), 32'(expv));
        check({tag, "_nowait"}, 32'(waitrequest), 32'd0);
        step(acc);
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        bit   a;
        int   t0;
        int   t1;
        int   npulse;
        logic [7:0] stream[9];
        int   r;
        int   nmin;

        stream = '{8'h01, "o", "p", "t", "i", "o", "n", " ", "1"};
        idle_steps(3);
        check("rst_lcd_en", 32'(lcd_en), 32'd0);
        check("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        check("rst_lcd_data", 32'(lcd_data), 32'd0);
        check("rst_readdata", 32'(readdata), 32'd0);
        check("rst_response", 32'(response), 32'd0);
        reset = 1'b0;

        // Single data write, then status reads while busy and after.
        write_held(1'b1, 8'h6F, t0);
        idle_steps(3);
        check("t4_cycle", 32'(cyc), 32'(t0 + 4));
        read_now(1'b0, 8'h80, "status_busy");
        idle_steps(6);
        read_now(1'b0, 8'h00, "status_idle");
        read_now(1'b1, 8'h6F, "data_readback");

        // Clear display holds off a following write for 17 cycles.
        write_held(1'b0, 8'h01, t0);
        write_held(1'b1, 8'h41, t1);
        check("clear_accept_cycle", 32'(t1), 32'(t0 + 17));

        // Held master stream.
        for (int i = 0; i < 9; i++) write_held(i != 0, stream[i], t1);

        // byteenable=0 write: SLAVEERROR and no E pulse.
        wait_idle();
        npulse = obs_pulses.size();
        chipselect = 1'b1; write = 1'b1; byteenable = 1'b0; address = 1'b1; writedata = 8'h55;
        #1;
        check("err_response", 32'(response), 32'd2);
        step(a);
        chipselect = 1'b0; write = 1'b0; byteenable = 1'b1;
        idle_steps(12);
        check("err_no_pulse", 32'(obs_pulses.size()), 32'(npulse));

        // Reset while E is high.
        write_held(1'b1, 8'h33, t0);
        idle_steps(3);
        #2;
        check("en_before_reset", 32'(lcd_en), 32'd1);
        reset = 1'b1;
        #1;
        check("en_async_reset", 32'(lcd_en), 32'd0);
        check("rs_async_reset", 32'(lcd_rs), 32'd0);
        check("data_async_reset", 32'(lcd_data), 32'd0);
        idle_steps(2);
        reset = 1'b0;
        prev_en = 1'b0;

        // Randomized mix of reads, writes, error writes and idle cycles.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            chipselect = (r >= 4) || ($urandom_range(0, 3) == 0);
            write      = (r >= 4 && r <= 6) || (r == 9);
            read       = (r >= 7);
            byteenable = ($urandom_range(0, 9) != 0);
            address    = 1'($urandom_range(0, 1));
            if (!address && $urandom_range(0, 2) == 0) writedata = 8'($urandom_range(1, 3));
            else writedata = 8'($urandom);
            step(a);
        end
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        wait_idle();
        idle_steps(2);

        check("pulse_count", 32'(obs_pulses.size()), 32'(exp_pulses.size()));
        nmin = (obs_pulses.size() < exp_pulses.size()) ? obs_pulses.size() : exp_pulses.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("pulse%0d", i), 32'(obs_pulses[i]), 32'(exp_pulses[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
